// File: rtl/siso_stream_buffer_pkg.sv
// siso_stream_buffer_pkg: shared state encoding, size macros and clog2 helper
`ifndef SISO_STREAM_BUFFER_PKG_SV
`define SISO_STREAM_BUFFER_PKG_SV
`define SISO_CAP(t, p) ((t) * ((p) - 1))
`define SISO_T_STEP(p, pu, g) ((p) * ((pu) + (g)))
package siso_stream_buffer_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STEP = 1'b1;
  function automatic int siso_clog2(input int n);
    for (int r = 0; r < 31; r++)
      if ((1 << r) >= n) return r;
    return 31;
  endfunction
endpackage
`endif

// File: rtl/siso_latch_chain.sv
// siso_latch_chain: mux-latch SISO storage, one latch slice per phase per tranche
module siso_latch_chain #(
  parameter int LANES    = 4,
  parameter int PHASES   = 4,
  parameter int TRANCHES = 4
) (
  input  logic [PHASES-1:0] pulse,
  input  logic [LANES-1:0]  din,
  output logic [LANES-1:0]  dout
);
  localparam int N = TRANCHES * PHASES;
  logic [LANES-1:0] node [N];
`ifdef SIM
  logic [PHASES-1:0] en;
  assign en = pulse;
`else
  (* keep *) logic [PHASES-1:0] pulse_n;
  (* keep *) logic [PHASES-1:0] en;
  assign pulse_n = ~pulse;
  assign en = ~pulse_n;
`endif
  for (genvar i = 0; i < N; i++) begin : g_slice
    logic [LANES-1:0] d;
    logic [LANES-1:0] q;
    if (i == 0) begin : g_in
      assign d = din;
    end else begin : g_link
      assign d = node[i-1];
    end
    // slice s of each tranche is transparent while pulse[PHASES-1-s] is high
    always_latch
      if (en[PHASES-1-(i%PHASES)]) q <= d;
    assign node[i] = q;
  end
  assign dout = node[N-1];
endmodule

// File: rtl/siso_stream_buffer.sv
// siso_stream_buffer: clocked sequencer driving the latch chain as a fixed-delay word line
module siso_stream_buffer
  import siso_stream_buffer_pkg::*;
#(
  parameter  int LANES    = 4,
  parameter  int PHASES   = 4,
  parameter  int TRANCHES = 4,
  parameter  int PULSE    = 1,
  parameter  int GAP      = 1,
  localparam int CAP      = `SISO_CAP(TRANCHES, PHASES),
  localparam int LW       = siso_clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  output logic [LANES-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             busy
);
  localparam int PW = siso_clog2(PHASES);
  localparam int CW = siso_clog2(PULSE + GAP);
  logic [0:0]        state, nxt_state;
  logic [PW-1:0]     phase, nxt_phase;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic [PHASES-1:0] pulse, nxt_pulse;
  logic [LANES-1:0]  in_reg, chain_out;
  logic [CAP-1:0]    vbits;
  logic              pend, go, end_slot, last;
  assign in_ready = state == IDLE;
  assign busy = ~in_ready;
  assign go = in_ready && (in_valid || flush);
  // next sequencer position; pulses are decoded from it so latch enables come straight from flops
  always_comb begin
    end_slot = cnt == CW'(PULSE + GAP - 1);
    last = state == STEP && end_slot && phase == PW'(PHASES - 1);
    nxt_state = go ? STEP : last ? IDLE : state;
    nxt_phase = (state == IDLE || last) ? '0 : end_slot ? phase + PW'(1) : phase;
    nxt_cnt = (state == IDLE || end_slot) ? '0 : cnt + CW'(1);
    nxt_pulse = (nxt_state == STEP && nxt_cnt < CW'(PULSE)) ? PHASES'(1) << nxt_phase : '0;
  end
  // sequencer, input/valid tracking and registered output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      cnt <= '0;
      pulse <= '0;
      in_reg <= '0;
      vbits <= '0;
      pend <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      level <= '0;
    end else begin
      state <= nxt_state;
      phase <= nxt_phase;
      cnt <= nxt_cnt;
      pulse <= nxt_pulse;
      out_valid <= last && pend;
      if (last) out_data <= chain_out;
      if (go) begin
        in_reg <= in_valid ? in_data : '0;
        vbits <= {vbits[CAP-2:0], in_valid};
        pend <= vbits[CAP-1];
        level <= level + LW'(in_valid) - LW'(vbits[CAP-1]);
      end
    end
  siso_latch_chain #(
    .LANES(LANES),
    .PHASES(PHASES),
    .TRANCHES(TRANCHES)
  ) u_chain (
    .pulse(pulse),
    .din(in_reg),
    .dout(chain_out)
  );
endmodule

// File: tb/tb_siso_stream_buffer.sv
// tb_siso_stream_buffer: directed checks of sequencing, delay, flush and reset behaviour
module tb_siso_stream_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       flush;
  logic       out_valid;
  logic [3:0] out_data;
  logic [3:0] level;
  logic       busy;
  int         total = 0;
  int         bad = 0;
  logic       ov;
  logic [3:0] od;
  logic [3:0] exp_t4 [12] = '{4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hA, 4'h5, 4'hF};

  siso_stream_buffer dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_data(out_data),
    .level(level),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic f, input logic [3:0] d,
                      output logic o_v, output logic [3:0] o_d);
    int n;
    in_valid = v;
    flush = f;
    in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    in_data = 4'h0;
    chk("busy_after_accept", busy, 1);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("step_done", in_ready, 1);
    o_v = out_valid;
    o_d = out_data;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    in_data = 4'h0;
    #23 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_pulse", dut.pulse, 0);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_level", level, 0);
    chk("t1_out_data", out_data, 0);
    chk("t1_busy", busy, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 4'(i), ov, od);
      chk("t2_no_out_valid", ov, 0);
      chk("t2_level", level, i);
    end
    step(1'b1, 1'b0, 4'hD, ov, od);
    chk("t2_13th_valid", ov, 1);
    chk("t2_13th_data", od, 4'h1);
    chk("t2_13th_level", level, 12);
    in_valid = 1'b1;
    in_data = 4'hE;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("t3_pulse", dut.pulse, (c % 2 == 0) ? (1 << (c / 2)) : 0);
      chk("t3_not_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("t3_ready_at_9", in_ready, 1);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data", out_data, 4'h2);
    @(posedge clk); #1;
    chk("t3_out_valid_pulse", out_valid, 0);
    step(1'b1, 1'b0, 4'hA, ov, od);
    chk("t4_load_a", od, 4'h3);
    step(1'b1, 1'b0, 4'h5, ov, od);
    chk("t4_load_5", od, 4'h4);
    step(1'b1, 1'b0, 4'hF, ov, od);
    chk("t4_load_f", od, 4'h5);
    chk("t4_level_full", level, 12);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, 4'h0, ov, od);
      chk("t4_flush_valid", ov, 1);
      chk("t4_flush_data", od, exp_t4[k]);
      chk("t4_flush_level", level, 11 - k);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 4'h0, ov, od);
      chk("t4_empty_valid", ov, 0);
      chk("t4_empty_data", od, 4'h0);
      chk("t4_empty_level", level, 0);
    end
    step(1'b1, 1'b1, 4'h3, ov, od);
    chk("t5_valid_first", ov, 0);
    chk("t5_level", level, 1);
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 1'b1, 4'h0, ov, od);
      chk("t5_wait_valid", ov, 0);
    end
    step(1'b0, 1'b1, 4'h0, ov, od);
    chk("t5_emerge_valid", ov, 1);
    chk("t5_emerge_data", od, 4'h3);
    chk("t5_level_after", level, 0);
    step(1'b1, 1'b0, 4'h7, ov, od);
    step(1'b1, 1'b0, 4'h8, ov, od);
    chk("t6_level_pre", level, 2);
    in_valid = 1'b1;
    in_data = 4'h9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pulse2", dut.pulse, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pulse_drop", dut.pulse, 0);
    chk("t6_level", level, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_in_ready", in_ready, 1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 4'(i), ov, od);
      chk("t6_no_out_valid", ov, 0);
    end
    step(1'b1, 1'b0, 4'h0, ov, od);
    chk("t6_first_valid", ov, 1);
    chk("t6_first_data", od, 4'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
